// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird game controller.
// Holds the state encoding, the LFSR seed and tap mask, and the default geometry.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  // Galois LFSR, taps 16,14,13,11, shifting right
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_SCR_W        = 640;
  localparam int DEF_GROUND_Y     = 440;
  localparam int DEF_BIRD_X       = 160;
  localparam int DEF_BIRD_SZ      = 16;
  localparam int DEF_START_Y      = 200;
  localparam int DEF_PIPE_W       = 52;
  localparam int DEF_PIPE_SPACING = 320;
  localparam int DEF_GAP_H        = 120;
  localparam int DEF_GAP_MIN      = 80;
  localparam int DEF_GRAVITY      = 1;
  localparam int DEF_FLAP_VEL     = -8;
  localparam int DEF_MAX_FALL     = 10;
  localparam int DEF_SCROLL       = 2;
  localparam int DEF_DEB_CYC      = 65536;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: two-flop synchroniser, stability counter, and a
// one-cycle pulse when the debounced level goes from 0 to 1.
module btn_debounce #(
  parameter int DEB_CYC = 65536
) (
  input  logic pix_clk,
  input  logic pix_rst,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [CW-1:0] cnt;

  // Synchronise, count how long the input has differed from the debounced level, adopt it once stable
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        deb   <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Flappy-bird game sequencer: game FSM, bird physics, two scrolling pipes,
// gap randomisation, collision detection and score, updated once per frame.
// Optional macro GAME_CTRL_HISCORE_EN adds a registered hiscore output.
module game_ctrl
  import game_pkg::*;
#(
  parameter int   SCR_W        = DEF_SCR_W,
  parameter int   GROUND_Y     = DEF_GROUND_Y,
  parameter int   BIRD_X       = DEF_BIRD_X,
  parameter int   BIRD_SZ      = DEF_BIRD_SZ,
  parameter int   START_Y      = DEF_START_Y,
  parameter int   PIPE_W       = DEF_PIPE_W,
  parameter int   PIPE_SPACING = DEF_PIPE_SPACING,
  parameter int   GAP_H        = DEF_GAP_H,
  parameter int   GAP_MIN      = DEF_GAP_MIN,
  parameter int   GRAVITY      = DEF_GRAVITY,
  parameter int   FLAP_VEL     = DEF_FLAP_VEL,
  parameter int   MAX_FALL     = DEF_MAX_FALL,
  parameter int   SCROLL       = DEF_SCROLL,
  parameter int   DEB_CYC      = DEF_DEB_CYC,
  parameter logic VS_POL       = 1'b1
) (
  input  logic               pix_clk,
  input  logic               pix_rst,
  input  logic               vsync,
  input  logic               button,
  output logic [1:0]         state,
  output logic [15:0]        bird_y,
  output logic signed [15:0] pipe0_x,
  output logic signed [15:0] pipe1_x,
  output logic [15:0]        pipe0_gap,
  output logic [15:0]        pipe1_gap,
  output logic [15:0]        score,
`ifdef GAME_CTRL_HISCORE_EN
  output logic [15:0]        hiscore,
`endif
  output logic               frame_tick
);

  localparam logic signed [15:0] BX16     = 16'(BIRD_X);
  localparam logic signed [15:0] BXR16    = 16'(BIRD_X + BIRD_SZ);
  localparam logic signed [15:0] PW16     = 16'(PIPE_W);
  localparam logic signed [15:0] SCROLL16 = 16'(SCROLL);
  localparam logic signed [15:0] WRAP16   = 16'(2 * PIPE_SPACING);
  localparam logic signed [15:0] PX0_RST  = 16'(SCR_W);
  localparam logic signed [15:0] PX1_RST  = 16'(SCR_W + PIPE_SPACING);
  localparam logic [15:0]        BSZ16    = 16'(BIRD_SZ);
  localparam logic [16:0]        BSZ17    = 17'(BIRD_SZ);
  localparam logic [16:0]        GROUND17 = 17'(GROUND_Y);
  localparam logic [15:0]        GAPMIN16 = 16'(GAP_MIN);
  localparam logic [15:0]        GAPH16   = 16'(GAP_H);
  localparam logic [15:0]        START16  = 16'(START_Y);
  localparam logic signed [7:0]  FLAP_V   = 8'(FLAP_VEL);
  localparam logic signed [8:0]  GRAV9    = 9'(GRAVITY);
  localparam logic signed [8:0]  MAXF9    = 9'(MAX_FALL);

  logic vs_cur;
  logic vs_prev;
  logic tick;
  logic press;
  logic flap_req;
  logic flap;
  logic [15:0] lfsr_q;

  game_state_t        state_q, state_d;
  logic [15:0]        bird_y_q, bird_y_d;
  logic signed [7:0]  vel_q, vel_d;
  logic signed [15:0] px_q [2];
  logic signed [15:0] px_d [2];
  logic [15:0]        gap_q [2];
  logic [15:0]        gap_d [2];
  logic [15:0]        score_q, score_d;
`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0]        hiscore_q, hiscore_d;
`endif

  logic signed [15:0] mv [2];
  logic signed [8:0]  vel_inc;
  logic signed [16:0] y_calc;
  logic [15:0]        new_y;
  logic [1:0]         cross_cnt;
  logic [16:0]        score_sum;
  logic               hit;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn (
    .pix_clk (pix_clk),
    .pix_rst (pix_rst),
    .button  (button),
    .press   (press)
  );

  assign tick = (vs_cur == VS_POL) && (vs_prev != VS_POL);
  assign flap = flap_req | press;

  // Register vsync edge detection, frame pulse, pending flap, LFSR and all game state
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      vs_cur     <= VS_POL;
      vs_prev    <= VS_POL;
      frame_tick <= 1'b0;
      flap_req   <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      state_q    <= ST_IDLE;
      bird_y_q   <= START16;
      vel_q      <= '0;
      px_q[0]    <= PX0_RST;
      px_q[1]    <= PX1_RST;
      gap_q[0]   <= GAPMIN16;
      gap_q[1]   <= GAPMIN16;
      score_q    <= '0;
`ifdef GAME_CTRL_HISCORE_EN
      hiscore_q  <= '0;
`endif
    end else begin
      vs_cur     <= vsync;
      vs_prev    <= vs_cur;
      frame_tick <= tick;
      flap_req   <= tick ? 1'b0 : flap;
      lfsr_q     <= lfsr_next(lfsr_q);
      state_q    <= state_d;
      bird_y_q   <= bird_y_d;
      vel_q      <= vel_d;
      px_q[0]    <= px_d[0];
      px_q[1]    <= px_d[1];
      gap_q[0]   <= gap_d[0];
      gap_q[1]   <= gap_d[1];
      score_q    <= score_d;
`ifdef GAME_CTRL_HISCORE_EN
      hiscore_q  <= hiscore_d;
`endif
    end
  end

  // Next-state: FSM transitions and per-frame physics, scroll, score and collision
  always_comb begin
    state_d   = state_q;
    bird_y_d  = bird_y_q;
    vel_d     = vel_q;
    score_d   = score_q;
    vel_inc   = '0;
    y_calc    = '0;
    new_y     = '0;
    cross_cnt = '0;
    score_sum = '0;
    hit       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      px_d[i]  = px_q[i];
      gap_d[i] = gap_q[i];
      mv[i]    = '0;
    end
`ifdef GAME_CTRL_HISCORE_EN
    hiscore_d = hiscore_q;
`endif

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (flap) begin
            state_d = ST_PLAY;
            vel_d   = FLAP_V;
            score_d = '0;
          end
        end

        ST_PLAY: begin
          vel_inc = 9'(vel_q) + GRAV9;
          if (flap)                 vel_d = FLAP_V;
          else if (vel_inc > MAXF9) vel_d = MAXF9[7:0];
          else                      vel_d = vel_inc[7:0];

          y_calc   = $signed({1'b0, bird_y_q}) + 17'(vel_d);
          new_y    = y_calc[16] ? 16'd0 : y_calc[15:0];
          bird_y_d = new_y;
          hit      = ({1'b0, new_y} + BSZ17) >= GROUND17;

          for (int i = 0; i < 2; i++) begin
            mv[i] = px_q[i] - SCROLL16;
            if ((px_q[i] + PW16 >= BX16) && (mv[i] + PW16 < BX16))
              cross_cnt = cross_cnt + 2'd1;
            if (mv[i] + PW16 <= 16'sd0) begin
              mv[i]    = mv[i] + WRAP16;
              gap_d[i] = GAPMIN16 + {9'd0, lfsr_q[6:0]};
            end
            px_d[i] = mv[i];
            if ((mv[i] < BXR16) && (mv[i] + PW16 > BX16) &&
                ((new_y < gap_d[i]) || (new_y + BSZ16 > gap_d[i] + GAPH16)))
              hit = 1'b1;
          end

          score_sum = {1'b0, score_q} + {15'd0, cross_cnt};
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          if (hit) state_d = ST_OVER;
        end

        ST_OVER: begin
          if (flap) begin
            state_d  = ST_IDLE;
            bird_y_d = START16;
            vel_d    = '0;
            px_d[0]  = PX0_RST;
            px_d[1]  = PX1_RST;
            gap_d[0] = GAPMIN16;
            gap_d[1] = GAPMIN16;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

`ifdef GAME_CTRL_HISCORE_EN
    if ((state_q == ST_PLAY) && (state_d == ST_OVER) && (score_d > hiscore_q))
      hiscore_d = score_d;
`endif
  end

  assign state     = state_q;
  assign bird_y    = bird_y_q;
  assign pipe0_x   = px_q[0];
  assign pipe1_x   = px_q[1];
  assign pipe0_gap = gap_q[0];
  assign pipe1_gap = gap_q[1];
  assign score     = score_q;
`ifdef GAME_CTRL_HISCORE_EN
  assign hiscore   = hiscore_q;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl with a behavioural game model feeding a
// scoreboard of expected per-frame states.
module tb_game_ctrl;

  logic               pix_clk = 1'b0;
  logic               pix_rst = 1'b1;
  logic               vsync   = 1'b0;
  logic               button  = 1'b0;
  logic [1:0]         state;
  logic [15:0]        bird_y;
  logic signed [15:0] pipe0_x;
  logic signed [15:0] pipe1_x;
  logic [15:0]        pipe0_gap;
  logic [15:0]        pipe1_gap;
  logic [15:0]        score;
  logic               frame_tick;
`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0]        hiscore;
`endif

  game_ctrl #(.DEB_CYC(4)) dut (
    .pix_clk    (pix_clk),
    .pix_rst    (pix_rst),
    .vsync      (vsync),
    .button     (button),
    .state      (state),
    .bird_y     (bird_y),
    .pipe0_x    (pipe0_x),
    .pipe1_x    (pipe1_x),
    .pipe0_gap  (pipe0_gap),
    .pipe1_gap  (pipe1_gap),
    .score      (score),
`ifdef GAME_CTRL_HISCORE_EN
    .hiscore    (hiscore),
`endif
    .frame_tick (frame_tick)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct {
    int st;
    int y;
    int p0;
    int p1;
    int g0;
    int g1;
    int sc;
    int hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural game model; a gap of -1 means it was randomised and is only range-checked
  int m_st, m_y, m_vel, m_sc, m_hi;
  int m_px [2];
  int m_gap [2];
  bit m_flap;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_st = 0; m_y = 200; m_vel = 0; m_sc = 0; m_hi = 0; m_flap = 0;
    m_px[0] = 640; m_px[1] = 960;
    m_gap[0] = 80; m_gap[1] = 80;
  endtask

  task automatic modelTick();
    bit f;
    bit coll;
    int oldx;
    f = m_flap;
    m_flap = 0;
    case (m_st)
      0: if (f) begin m_st = 1; m_vel = -8; m_sc = 0; end
      1: begin
        m_vel = f ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
        m_y = m_y + m_vel;
        if (m_y < 0) m_y = 0;
        coll = (m_y + 16 >= 440);
        for (int i = 0; i < 2; i++) begin
          oldx = m_px[i];
          m_px[i] = m_px[i] - 2;
          if (oldx + 52 >= 160 && m_px[i] + 52 < 160) m_sc = m_sc + 1;
          if (m_px[i] + 52 <= 0) begin
            m_px[i] = m_px[i] + 640;
            m_gap[i] = -1;
          end
          if (m_gap[i] >= 0 && m_px[i] < 176 && m_px[i] + 52 > 160 &&
              (m_y < m_gap[i] || m_y + 16 > m_gap[i] + 120))
            coll = 1;
        end
        if (m_sc > 65535) m_sc = 65535;
        if (coll) begin
          m_st = 2;
          if (m_sc > m_hi) m_hi = m_sc;
        end
      end
      2: if (f) begin
        m_st = 0; m_y = 200; m_vel = 0;
        m_px[0] = 640; m_px[1] = 960;
        m_gap[0] = 80; m_gap[1] = 80;
      end
      default: ;
    endcase
  endtask

  // One frame: optional debounced press, model update, scoreboard push, then a vsync pulse
  task automatic applyStimulus(input bit flap);
    if (flap) begin
      button = 1'b1;
      repeat (12) @(negedge pix_clk);
      button = 1'b0;
      repeat (12) @(negedge pix_clk);
      m_flap = 1;
    end
    modelTick();
    sb.push_back('{m_st, m_y, m_px[0], m_px[1], m_gap[0], m_gap[1], m_sc, m_hi});
    vsync = 1'b1;
    repeat (4) @(negedge pix_clk);
    vsync = 1'b0;
    repeat (4) @(negedge pix_clk);
  endtask

  task automatic checkGap(input string tag, input int observed, input int expected);
    if (expected < 0) checkOutput(tag, int'(observed >= 80 && observed <= 207), 1);
    else              checkOutput(tag, observed, expected);
  endtask

  // Compare every reported frame against the oldest expected entry
  always @(negedge pix_clk) begin
    if (!pix_rst && frame_tick) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_frame_tick", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("frame_state", int'(state), mon_e.st);
        checkOutput("frame_bird_y", int'(bird_y), mon_e.y);
        checkOutput("frame_pipe0_x", int'(pipe0_x), mon_e.p0);
        checkOutput("frame_pipe1_x", int'(pipe1_x), mon_e.p1);
        checkGap("frame_pipe0_gap", int'(pipe0_gap), mon_e.g0);
        checkGap("frame_pipe1_gap", int'(pipe1_gap), mon_e.g1);
        checkOutput("frame_score", int'(score), mon_e.sc);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("frame_hiscore", int'(hiscore), mon_e.hi);
`endif
      end
    end
  end

  initial begin
    modelReset();
    pix_rst = 1'b1;
    repeat (3) @(negedge pix_clk);
    pix_rst = 1'b0;
    @(negedge pix_clk);

    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_bird_y", int'(bird_y), 200);
    checkOutput("rst_pipe0_x", int'(pipe0_x), 640);
    checkOutput("rst_pipe1_x", int'(pipe1_x), 960);
    checkOutput("rst_pipe0_gap", int'(pipe0_gap), 80);
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_frame_tick", int'(frame_tick), 0);
`ifdef GAME_CTRL_HISCORE_EN
    checkOutput("rst_hiscore", int'(hiscore), 0);
`endif

    // Idle frames without a button: nothing moves, one frame pulse each
    repeat (3) applyStimulus(1'b0);
    repeat (2) @(negedge pix_clk);
    checkOutput("idle_ticks_seen", sb.size(), 0);

    // Short glitches never survive the debounce
    repeat (3) begin
      button = 1'b1;
      repeat (2) @(negedge pix_clk);
      button = 1'b0;
      repeat (8) @(negedge pix_clk);
    end
    applyStimulus(1'b0);
    checkOutput("glitch_still_idle", int'(state), 0);

    // Start, flap once more, then coast: expect 200, 192, 185
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("coast_bird_y", int'(bird_y), 185);

    // Hold altitude through pipe0 until it wraps, then stop flapping and fall
    for (int n = 0; n < 700 && m_st == 1; n++) begin
      bit f;
      f = (m_gap[0] < 0) ? 1'b0 : (m_vel > 0 && m_y > 160);
      applyStimulus(f);
    end
    checkOutput("game_over_state", int'(state), 2);
    checkOutput("game_over_score", int'(score), 1);

    // Frozen in OVER, then back to IDLE with positions reloaded and score held
    repeat (2) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("reload_state", int'(state), 0);
    checkOutput("reload_score_held", int'(score), 1);
`ifdef GAME_CTRL_HISCORE_EN
    checkOutput("hiscore_kept", int'(hiscore), 1);
`endif

    // Reset mid-game with a flap pending: everything returns to reset values
    applyStimulus(1'b1);
    button = 1'b1;
    repeat (12) @(negedge pix_clk);
    button = 1'b0;
    repeat (12) @(negedge pix_clk);
    pix_rst = 1'b1;
    repeat (2) @(negedge pix_clk);
    pix_rst = 1'b0;
    modelReset();
    @(negedge pix_clk);
    checkOutput("midrst_state", int'(state), 0);
    checkOutput("midrst_bird_y", int'(bird_y), 200);
    checkOutput("midrst_score", int'(score), 0);
`ifdef GAME_CTRL_HISCORE_EN
    checkOutput("midrst_hiscore", int'(hiscore), 0);
`endif
    applyStimulus(1'b0);
    checkOutput("midrst_flap_dropped", int'(state), 0);

    repeat (5) @(negedge pix_clk);
    checkOutput("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
